// File: rtl/mymod.sv
// Sliding-window accumulator: keeps the last Y accepted samples and outputs
// X times their sum, saturated to 16 bits, one cycle after each acceptance.
module mymod #(
    parameter int unsigned X = 1,
    parameter int unsigned Y = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  foo,
    input  logic        foo_vld,
    input  logic        clr,
    output logic [15:0] sum,
    output logic        sum_vld,
    output logic        full,
    output logic [4:0]  count
);

    localparam int unsigned SW   = 9;
    localparam int unsigned RW   = 13;
    localparam int unsigned CW   = 5;
    localparam int unsigned SUMW = 16;
    localparam int unsigned PW   = RW + 8;

    // win_q[0] is the oldest entry, win_q[Y-1] the newest
    logic [SW-1:0]   win_q [Y];
    logic [RW-1:0]   run_q;
    logic [RW-1:0]   run_nxt;
    logic [SW-1:0]   disc;
    logic [CW-1:0]   cnt_nxt;
    logic [PW-1:0]   prod;
    logic [SUMW-1:0] sat;
    logic            accept;

    assign full = (count == CW'(Y));

    // Incremental running sum and saturated gain product for the next acceptance
    always_comb begin
        accept  = foo_vld & ~clr;
        disc    = full ? win_q[0] : '0;
        run_nxt = run_q + RW'(foo) - RW'(disc);
        cnt_nxt = full ? count : count + CW'(1);
        prod    = PW'(X) * PW'(run_nxt);
        sat     = (prod > PW'(65535)) ? '1 : prod[SUMW-1:0];
    end

    // Reset and clear both empty the window; clear wins over a same-edge sample
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < int'(Y); i++) begin
                win_q[i] <= '0;
            end
            run_q   <= '0;
            count   <= '0;
            sum     <= '0;
            sum_vld <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < int'(Y) - 1; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[Y-1] <= foo;
            run_q      <= run_nxt;
            count      <= cnt_nxt;
            sum        <= sat;
            sum_vld    <= (cnt_nxt == CW'(Y));
        end else begin
            sum_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mymod.sv
// Scoreboard bench for mymod: four instances (X/Y = 1/2, 3/2, 255/2, 2/1) share
// directed stimulus; the driver queues hand-computed expectations, a monitor checks them.
module tb_mymod;

    logic        clk;
    logic        rst_n;
    logic [8:0]  foo;
    logic        foo_vld;
    logic        clr;

    logic [15:0] sum_a, sum_b, sum_c, sum_d;
    logic        vld_a, vld_b, vld_c, vld_d;
    logic        full_a, full_b, full_c, full_d;
    logic [4:0]  cnt_a, cnt_b, cnt_c, cnt_d;

    typedef struct {
        logic [15:0] sa;
        logic [15:0] sb;
        logic [15:0] sc;
        logic        v2;
        logic [4:0]  c2;
        logic        f2;
        logic [15:0] sd;
        logic        vd;
        logic [4:0]  cd;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mymod #(.X(1),   .Y(2)) u_a (.clk(clk), .rst_n(rst_n), .foo(foo), .foo_vld(foo_vld), .clr(clr),
                                 .sum(sum_a), .sum_vld(vld_a), .full(full_a), .count(cnt_a));
    mymod #(.X(3),   .Y(2)) u_b (.clk(clk), .rst_n(rst_n), .foo(foo), .foo_vld(foo_vld), .clr(clr),
                                 .sum(sum_b), .sum_vld(vld_b), .full(full_b), .count(cnt_b));
    mymod #(.X(255), .Y(2)) u_c (.clk(clk), .rst_n(rst_n), .foo(foo), .foo_vld(foo_vld), .clr(clr),
                                 .sum(sum_c), .sum_vld(vld_c), .full(full_c), .count(cnt_c));
    mymod #(.X(2),   .Y(1)) u_d (.clk(clk), .rst_n(rst_n), .foo(foo), .foo_vld(foo_vld), .clr(clr),
                                 .sum(sum_d), .sum_vld(vld_d), .full(full_d), .count(cnt_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, req);
        end
    endtask

    // Drive one edge's inputs on the falling edge and queue what the outputs must be after it
    task automatic step(input logic r, input logic c, input logic v, input int d,
                        input int sa, input int sb, input int sc, input int v2, input int c2,
                        input int sd, input int vd, input int cd);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        clr     = c;
        foo_vld = v;
        foo     = 9'(d);
        e.sa = 16'(sa); e.sb = 16'(sb); e.sc = 16'(sc);
        e.v2 = 1'(v2);  e.c2 = 5'(c2);  e.f2 = (c2 == 2);
        e.sd = 16'(sd); e.vd = 1'(vd);  e.cd = 5'(cd);  e.fd = (cd == 1);
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per active edge and compares every output
    int mstep = 0;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            mstep++;
            check("sum_x1",   mstep, int'(sum_a),  int'(e.sa));
            check("sum_x3",   mstep, int'(sum_b),  int'(e.sb));
            check("sum_x255", mstep, int'(sum_c),  int'(e.sc));
            check("vld_x1",   mstep, int'(vld_a),  int'(e.v2));
            check("vld_x3",   mstep, int'(vld_b),  int'(e.v2));
            check("vld_x255", mstep, int'(vld_c),  int'(e.v2));
            check("count_y2", mstep, int'(cnt_a),  int'(e.c2));
            check("full_y2",  mstep, int'(full_a), int'(e.f2));
            check("sum_y1",   mstep, int'(sum_d),  int'(e.sd));
            check("vld_y1",   mstep, int'(vld_d),  int'(e.vd));
            check("count_y1", mstep, int'(cnt_d),  int'(e.cd));
            check("full_y1",  mstep, int'(full_d), int'(e.fd));
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; foo_vld = 1'b0; foo = '0;
        //    rst clr vld foo   sa    sb    sc     v2 c2  sd    vd cd
        step(0, 0, 0, 0,     0,    0,    0,     0, 0,  0,    0, 0);
        step(0, 0, 1, 8,     0,    0,    0,     0, 0,  0,    0, 0);
        step(1, 0, 1, 5,     5,    15,   1275,  0, 1,  10,   1, 1);
        step(1, 0, 1, 7,     12,   36,   3060,  1, 2,  14,   1, 1);
        step(1, 0, 1, 10,    17,   51,   4335,  1, 2,  20,   1, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 99, 17,  51,   4335,  0, 2,  20,   0, 1);
        end
        step(1, 1, 1, 9,     0,    0,    0,     0, 0,  0,    0, 0);
        step(1, 0, 1, 4,     4,    12,   1020,  0, 1,  8,    1, 1);
        step(1, 0, 1, 511,   515,  1545, 65535, 1, 2,  1022, 1, 1);
        step(1, 0, 1, 511,   1022, 3066, 65535, 1, 2,  1022, 1, 1);
        step(0, 0, 1, 3,     0,    0,    0,     0, 0,  0,    0, 0);
        step(1, 0, 1, 6,     6,    18,   1530,  0, 1,  12,   1, 1);
        step(1, 0, 0, 0,     6,    18,   1530,  0, 1,  12,   0, 1);
        step(1, 1, 0, 0,     0,    0,    0,     0, 0,  0,    0, 0);
        step(1, 0, 0, 0,     0,    0,    0,     0, 0,  0,    0, 0);
        repeat (3) @(negedge clk);
        check("queue_drained", mstep, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
